// File: rtl/vend_change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending datapath: the 2-bit coin encoding used on
// both the coin input path and the change hopper, a code-to-rupees helper, and
// the state encoding of the change dispenser FSM.
// -----------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_R1   = 2'b01;
  localparam logic [1:0] COIN_R2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISPENSE,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } disp_state_e;

  // Rupee value of a coin code; the unused code 11 is worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_R1: return 2'd1;
      COIN_R2: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser_if
// Request, hopper and status signals of the change dispenser.
//   req_valid/req_ready/req_amount : change request handshake
//   coin_valid/coin_out/coin_ack   : one-coin-at-a-time hopper handshake
//   hopper1_empty/hopper2_empty    : hopper stock flags
//   busy/done/error/shortfall      : transaction status
// master = requester/hopper side, slave = dispenser side.
// -----------------------------------------------------------------------------
interface vend_change_dispenser_if #(
  parameter int AMT_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             coin_valid;
  logic [1:0]       coin_out;
  logic             coin_ack;
  logic             hopper1_empty;
  logic             hopper2_empty;
  logic             busy;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] shortfall;

  modport master (
    output req_valid, req_amount, coin_ack, hopper1_empty, hopper2_empty,
    input  req_ready, coin_valid, coin_out, busy, done, error, shortfall
  );

  modport slave (
    input  req_valid, req_amount, coin_ack, hopper1_empty, hopper2_empty,
    output req_ready, coin_valid, coin_out, busy, done, error, shortfall
  );

endinterface

// File: rtl/vend_change_dispenser_timer.sv
// -----------------------------------------------------------------------------
// vend_cycle_timer
// Loadable down-counter with an expiry flag. Loading N makes expired assert
// after N enabled cycles, so a phase that must last K cycles loads K-1 and
// leaves on the cycle expired is high.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_value (takes priority over counting)
//   load_value : start count
//   enable     : count down by one per cycle, saturating at zero
//   expired    : count is zero
// -----------------------------------------------------------------------------
module vend_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// -----------------------------------------------------------------------------
// vend_change_dispenser
// Pays out a change amount one coin at a time, preferring two-rupee coins and
// falling back to one-rupee coins when the two-rupee hopper is empty. Any
// amount that cannot be paid (empty hoppers or hopper ack timeout) is reported
// as shortfall with an error pulse alongside done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vend_change_dispenser_if.slave (request, hopper, status)
// All outputs are registered; each is derived from the next state so it lines
// up with the state it describes.
// -----------------------------------------------------------------------------
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  vend_change_dispenser_if.slave  bus
);

  localparam int TMR_W = 8;
  // Both phases leave on the cycle the timer reads zero, hence the -1.
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  disp_state_e      state_reg, state_next;
  logic [AMT_W-1:0] remaining_reg, remaining_next;
  logic [AMT_W-1:0] shortfall_reg, shortfall_next;
  logic [1:0]       coin_reg, coin_next;
  logic             req_ready_reg;
  logic             coin_valid_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_value;
  logic             tmr_enable;
  logic             tmr_expired;

  // One timer serves both the ack timeout and the inter-coin gap; the two
  // phases never overlap, and each is reloaded on entry.
  vend_cycle_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .enable     (tmr_enable),
    .expired    (tmr_expired)
  );

  assign tmr_enable = (state_reg == ST_DISPENSE) || (state_reg == ST_GAP);

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    shortfall_next = shortfall_reg;
    coin_next      = coin_reg;
    tmr_load       = 1'b0;
    tmr_load_value = ACK_LOAD;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_reg) begin
          remaining_next = bus.req_amount;
          shortfall_next = '0;
          state_next     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (remaining_reg == '0) begin
          state_next = ST_DONE;
        end else if ((remaining_reg >= AMT_W'(2)) && !bus.hopper2_empty) begin
          coin_next      = COIN_R2;
          tmr_load       = 1'b1;
          tmr_load_value = ACK_LOAD;
          state_next     = ST_DISPENSE;
        end else if (!bus.hopper1_empty) begin
          // remaining is non-zero here, so a one-rupee coin always fits.
          coin_next      = COIN_R1;
          tmr_load       = 1'b1;
          tmr_load_value = ACK_LOAD;
          state_next     = ST_DISPENSE;
        end else begin
          shortfall_next = remaining_reg;
          state_next     = ST_FAIL;
        end
      end

      ST_DISPENSE: begin
        // Ack is checked first so an ack on the final timeout cycle still
        // counts the coin.
        if (bus.coin_ack) begin
          remaining_next = remaining_reg - AMT_W'(coin_value(coin_reg));
          coin_next      = COIN_NONE;
          tmr_load       = 1'b1;
          tmr_load_value = GAP_LOAD;
          state_next     = ST_GAP;
        end else if (tmr_expired) begin
          coin_next      = COIN_NONE;
          shortfall_next = remaining_reg;
          state_next     = ST_FAIL;
        end
      end

      ST_GAP: begin
        if (tmr_expired) begin
          state_next = ST_SELECT;
        end
      end

      ST_DONE: state_next = ST_IDLE;
      ST_FAIL: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      remaining_reg  <= '0;
      shortfall_reg  <= '0;
      coin_reg       <= COIN_NONE;
      req_ready_reg  <= 1'b1;
      coin_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      shortfall_reg  <= shortfall_next;
      coin_reg       <= coin_next;
      req_ready_reg  <= (state_next == ST_IDLE);
      coin_valid_reg <= (state_next == ST_DISPENSE);
      busy_reg       <= (state_next != ST_IDLE);
      done_reg       <= (state_next == ST_DONE) || (state_next == ST_FAIL);
      error_reg      <= (state_next == ST_FAIL);
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.coin_valid = coin_valid_reg;
  assign bus.coin_out   = coin_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.error      = error_reg;
  assign bus.shortfall  = shortfall_reg;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_vend_change_dispenser
// Directed stimulus with a scoreboard: each test pushes the coins and the
// completion it expects, and an independent monitor pops and compares them as
// the dispenser presents coins and done pulses.
// -----------------------------------------------------------------------------
module tb_vend_change_dispenser;
  import vend_pkg::*;

  localparam int AMT_W       = 4;
  localparam int ACK_TIMEOUT = 15;
  localparam int GAP_CYCLES  = 2;

  typedef struct {
    bit         is_done;
    logic [1:0] coin;
    int         hold;
    bit         err;
    int         sf;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;

  vend_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  vend_change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   coins_seen = 0;
  int   dones_seen = 0;
  bit   ack_en     = 1'b1;
  int   ack_delay  = 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic exp_coin(input logic [1:0] code, input int hold);
    exp_t e;
    e = '{is_done: 1'b0, coin: code, hold: hold, err: 1'b0, sf: 0, lat: 0};
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input bit err, input int sf, input int lat);
    exp_t e;
    e = '{is_done: 1'b1, coin: COIN_NONE, hold: 0, err: err, sf: sf, lat: lat};
    exp_q.push_back(e);
  endtask

  // Hopper model: acks ack_delay cycles after a coin first appears.
  initial begin
    int ack_cnt;
    ack_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.coin_valid && ack_en) begin
        bus.coin_ack = (ack_cnt == ack_delay);
        ack_cnt++;
      end else begin
        bus.coin_ack = 1'b0;
        ack_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard checker, sampling 1 time unit after each edge.
  initial begin
    bit         coin_active, gap_armed, stable, prev_ready;
    int         hold_cnt, low_cnt, cur_hold, cyc, accept_cyc;
    logic [1:0] cur_code;
    exp_t       e;
    coin_active = 0; gap_armed = 0; stable = 1; prev_ready = 1;
    hold_cnt = 0; low_cnt = 0; cur_hold = 0; cyc = 0; accept_cyc = 0;
    cur_code = COIN_NONE;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        coin_active = 0;
        gap_armed   = 0;
        prev_ready  = bus.req_ready;
        continue;
      end
      if (bus.req_valid && prev_ready) accept_cyc = cyc - 1;
      prev_ready = bus.req_ready;

      if (bus.coin_valid) begin
        if (!coin_active) begin
          coin_active = 1; hold_cnt = 1; stable = 1; coins_seen++;
          if (gap_armed) check("coin_gap", low_cnt, GAP_CYCLES + 1);
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            n_checks++;
            $display("FAIL unexpected_coin: got code %0d expected no coin", bus.coin_out);
            cur_code = bus.coin_out; cur_hold = 0;
          end else begin
            e = exp_q.pop_front();
            check("coin_code", int'(bus.coin_out), int'(e.coin));
            cur_code = e.coin; cur_hold = e.hold;
          end
        end else begin
          hold_cnt++;
          if (bus.coin_out != cur_code) stable = 0;
        end
      end else begin
        if (coin_active) begin
          coin_active = 0;
          if (cur_hold != 0) check("coin_hold", hold_cnt, cur_hold);
          check("coin_stable", int'(stable), 1);
          gap_armed = 1;
          low_cnt   = 1;
        end else begin
          low_cnt++;
        end
      end

      if (bus.done) begin
        dones_seen++;
        gap_armed = 0;
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          n_checks++;
          $display("FAIL unexpected_done: got done error=%0d shortfall=%0d expected no done",
                   bus.error, bus.shortfall);
        end else begin
          e = exp_q.pop_front();
          check("done_error", int'(bus.error), int'(e.err));
          check("done_shortfall", int'(bus.shortfall), e.sf);
          check("done_busy", int'(bus.busy), 1);
          if (e.lat != 0) check("done_latency", cyc - accept_cyc, e.lat);
        end
      end
    end
  end

  task automatic send(input int amount);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!bus.req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(amount);
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start, budget;
    start = dones_seen;
    budget = 0;
    while (dones_seen == start && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (dones_seen == start) check(name, 0, 1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_amount = '0; bus.coin_ack = 1'b0;
    bus.hopper1_empty = 1'b0; bus.hopper2_empty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_coin_valid", int'(bus.coin_valid), 0);
    check("rst_coin_out", int'(bus.coin_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_shortfall", int'(bus.shortfall), 0);
    rst = 1'b0;

    // 5 rupees, both hoppers stocked: 2+2+1.
    ack_en = 1; ack_delay = 1;
    exp_coin(COIN_R2, 2); exp_coin(COIN_R2, 2); exp_coin(COIN_R1, 2);
    exp_done(0, 0, 0);
    send(5);
    wait_done("t1_done_timeout");
    $display("txn amount=5 full hoppers complete");

    // 3 rupees, no two-rupee coins; a request while busy must be ignored.
    bus.hopper2_empty = 1'b1;
    exp_coin(COIN_R1, 2); exp_coin(COIN_R1, 2); exp_coin(COIN_R1, 2);
    exp_done(0, 0, 0);
    send(3);
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_amount = AMT_W'(7);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done("t2_done_timeout");
    bus.hopper2_empty = 1'b0;
    $display("txn amount=3 hopper2 empty complete");

    // 5 rupees, no one-rupee coins: 2+2 then one rupee short.
    bus.hopper1_empty = 1'b1;
    exp_coin(COIN_R2, 2); exp_coin(COIN_R2, 2);
    exp_done(1, 1, 0);
    send(5);
    wait_done("t3_done_timeout");
    repeat (3) @(negedge clk);
    check("shortfall_hold", int'(bus.shortfall), 1);
    bus.hopper1_empty = 1'b0;
    $display("txn amount=5 hopper1 empty complete");

    // 4 rupees, hopper never acks: coin held for the full timeout.
    ack_en = 0;
    exp_coin(COIN_R2, ACK_TIMEOUT);
    exp_done(1, 4, 0);
    send(4);
    wait_done("t4_done_timeout");
    $display("txn amount=4 no ack complete");

    // 4 rupees, ack on the last timeout cycle: each coin still counts.
    ack_en = 1; ack_delay = ACK_TIMEOUT - 1;
    exp_coin(COIN_R2, ACK_TIMEOUT); exp_coin(COIN_R2, ACK_TIMEOUT);
    exp_done(0, 0, 0);
    send(4);
    wait_done("t5_done_timeout");
    check("shortfall_cleared", int'(bus.shortfall), 0);
    $display("txn amount=4 late ack complete");

    // Zero amount: done two cycles after acceptance, no coin.
    ack_delay = 1;
    exp_done(0, 0, 2);
    send(0);
    wait_done("t6_done_timeout");
    $display("txn amount=0 complete");

    // Maximum amount pays out fully.
    for (int i = 0; i < 7; i++) exp_coin(COIN_R2, 2);
    exp_coin(COIN_R1, 2);
    exp_done(0, 0, 0);
    send(15);
    wait_done("t7_done_timeout");
    $display("txn amount=15 complete");

    // 6 rupees, reset during the second coin.
    exp_coin(COIN_R2, 2); exp_coin(COIN_R2, 0);
    base = coins_seen;
    send(6);
    for (int i = 0; i < 200 && coins_seen < base + 2; i++) @(negedge clk);
    check("t8_second_coin_seen", coins_seen - base, 2);
    base = dones_seen;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_coin_valid", int'(bus.coin_valid), 0);
    check("mid_rst_req_ready", int'(bus.req_ready), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", dones_seen - base, 0);
    $display("txn amount=6 reset mid-payout complete");

    // Fresh 2-rupee request after the reset.
    exp_coin(COIN_R2, 2);
    exp_done(0, 0, 0);
    send(2);
    wait_done("t9_done_timeout");
    $display("txn amount=2 after reset complete");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("total_dones", dones_seen, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
